// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single unified memory port: grants CPU or loader,
// holds the strobe for LAT cycles, returns read data and pulses the owner's ready.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LAT      = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ready,
  input  logic          l_req,
  input  logic          l_wr,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ready,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_rd,
  output logic          m_wr,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          wr_l;
  logic          last;
  logic          any_req;
  logic          pick_l;

  assign any_req = c_req | l_req;

  // On a tie the loader wins only in round-robin mode when the CPU went last.
  always_comb begin
    pick_l = 1'b0;
    if (l_req && !c_req) begin
      pick_l = 1'b1;
    end else if (l_req && c_req) begin
      pick_l = (CPU_PRIO == 0) && !last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr  <= '0;
      m_wdata <= '0;
      wr_l    <= 1'b0;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      c_rdata <= '0;
      l_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= pick_l;
            m_addr  <= pick_l ? l_addr  : c_addr;
            m_wdata <= pick_l ? l_wdata : c_wdata;
            wr_l    <= pick_l ? l_wr    : c_wr;
            cnt     <= CW'(LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!wr_l) begin
            if (owner) l_rdata <= m_rdata;
            else       c_rdata <= m_rdata;
          end
        end
        DONE: begin
          last <= owner;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend only on registered state, never on requester inputs.
  assign m_rd    = (state == ACCESS) && !wr_l;
  assign m_wr    = (state == ACCESS) &&  wr_l;
  assign busy    = (state != IDLE);
  assign c_ready = (state == DONE) && !owner;
  assign l_ready = (state == DONE) &&  owner;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter placed between the multicycle CPU's single unified memory port and a second requester: a program/data loader or debug port. It grants the memory to one requester at a time and latches that requester's address, data and direction. It holds the memory strobes for a parameterised number of wait cycles, returns read data, and pulses a one-cycle `ready` to the owner. The CPU control unit uses `c_ready` as its stall release for fetch, load and store states.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LAT`, 1: cycles the memory strobe is held per access. Must be ≥ 1; `LAT = 0` is illegal.
- `CPU_PRIO`, 0: tie policy. 0 = round-robin; 1 = CPU always wins a tie.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `c_req`  in  1: CPU request.
- `c_wr`  in  1: CPU direction; 1 = write, 0 = read.
- `c_addr`  in  AW: CPU address.
- `c_wdata`  in  DW: CPU write data.
- `c_rdata`  out  DW: CPU read data, registered.
- `c_ready`  out  1: one-cycle completion pulse to the CPU.
- `l_req`, `l_wr`, `l_addr`, `l_wdata`, `l_rdata`, `l_ready`: loader port; same widths and meaning as the CPU port.
- `m_addr`  out  AW: address to memory.
- `m_wdata`  out  DW: write data to memory.
- `m_rd`  out  1: memory read strobe.
- `m_wr`  out  1: memory write strobe.
- `m_rdata`  in  DW: data from memory; valid while `m_rd` is high.
- `busy`  out  1: high whenever the state is not IDLE.
- `owner`  out  1: current or last grant; 0 = CPU, 1 = loader.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. The strobes, `ready` and `busy` are decoded from registered state only, so they are glitch-free.
- **IDLE**
  - If no `req` is high, stay in IDLE.
  - Otherwise pick the winner:
    - Only one `req` high: that requester wins.
    - Both high with `CPU_PRIO = 1`: CPU wins.
    - Both high with `CPU_PRIO = 0`: the requester that is not `last` wins.
  - Latch the winner's `addr`, `wdata` and `wr` into internal registers, and set `owner`.
  - Load `cnt = LAT-1` and go to ACCESS.
- **ACCESS**
  - Drive `m_addr` and `m_wdata` from the latches. Assert `m_rd = !wr_l` or `m_wr = wr_l`.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0` and the access is a read, capture `m_rdata` into the owner's `rdata` register. Then go to DONE.
- **DONE**
  - Strobes are low and the owner's `ready` is high.
  - Set `last = owner` and go to IDLE.
- Requester rules:
  - Hold `req`, `addr`, `wdata` and `wr` stable until `ready` is seen.
  - Inputs are sampled only in IDLE; changes during ACCESS or DONE are ignored.
  - Dropping `req` during ACCESS does not abort the access: it completes and `ready` still pulses.
  - A `req` still high in the IDLE cycle after DONE is a new request.
- `rdata` holds its value until the next completed read by that same port. Writes never change `rdata`, and the non-owner's `rdata` is untouched.
- `m_addr` and `m_wdata` keep their latched values in IDLE and DONE.
- Counter width is `clog2(LAT+1)`.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `m_rd`, `m_wr`, `c_ready`, `l_ready`, `busy` and `owner` go to 0.
  - `m_addr`, `m_wdata`, `c_rdata` and `l_rdata` go to 0.
  - `last` is set to 1, so the CPU wins the first tie; `cnt` goes to 0.
- Reset during ACCESS drops the strobes immediately. A write in progress may be incomplete; this is accepted.
- Latency, with the request sampled in IDLE at edge 0:
  - ACCESS occupies cycles 1..LAT.
  - DONE with `ready` high is cycle LAT+1.
  - The next grant is sampled at the end of the following IDLE cycle.
  - Throughput for back-to-back requests is one access per LAT+2 cycles.
- `rdata` is valid in the same cycle that `ready` is high, and after it.
- Fairness: with both requesters continuously requesting and `CPU_PRIO = 0`, grants alternate C, L, C, L.

## Test plan
- **Reset:** assert `rst` mid-idle with random inputs → every output is 0. Release, then raise `c_req` and `l_req` together → first grant has `owner = 0`.
- **CPU read, `LAT = 2`:** `c_req = 1`, `c_wr = 0`, `c_addr = 0x40`, memory returns 0xDEADBEEF → `m_rd` high for exactly 2 cycles with `m_addr = 0x40`. `c_ready` is high in cycle 3 with `c_rdata = 0xDEADBEEF`; `l_rdata` is unchanged.
- **Loader write, `LAT = 1`:** `l_wr = 1`, `l_addr = 0x100`, `l_wdata = 0x12345678` → `m_wr` high for 1 cycle with those values. `l_ready` pulses once; `c_rdata` and `l_rdata` do not change.
- **Round-robin:** both `req` held high for 6 accesses with `CPU_PRIO = 0` → owners are 0,1,0,1,0,1. With `CPU_PRIO = 1` → owners are 0,0,0,0,0,0.
- **Request dropped:** `c_req` deasserted in the first ACCESS cycle → the access still runs `LAT` cycles and `c_ready` pulses once. The FSM then returns to IDLE with `busy = 0`.
- **Reset mid-write:** assert `rst` in the 2nd cycle of a `LAT = 3` write → `m_wr` goes low in the same cycle and the FSM is in IDLE. No `ready` pulse is produced.
